// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
// Bundle of the mux handshake and data signals between a traffic source/sink
// (master) and the stream_mux_rr block (slave).
//   mode      : 0 = fixed channel select, 1 = round-robin arbitration
//   sel       : channel index used in fixed mode
//   in_data   : packed channel data, channel k at [k*DW +: DW]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready (driven by the mux, combinational)
//   out_data  : registered output data
//   out_valid : registered output valid
//   out_ch    : registered index of the channel that sourced out_data
//   out_ready : downstream ready
interface stream_mux_rr_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8
);
    localparam int SW = $clog2(N_CH);

    logic                 mode;
    logic [SW-1:0]        sel;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_ready;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic [SW-1:0]        out_ch;
    logic                 out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N_CH-to-1 valid/ready stream multiplexer with a single-entry output register.
// Fixed mode forwards channel 'sel'; round-robin mode grants the first valid
// channel at or after a rotating pointer, which advances past each winner.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears the output register and pointer
//   bus   : stream_mux_rr_if slave view (mode, sel, in_*, out_*)
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int DW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_mux_rr_if.slave bus
);
    localparam int SW = $clog2(N_CH);
    localparam logic [SW:0] N_CH_W = (SW+1)'(N_CH);

    logic [DW-1:0]   out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [SW-1:0]   out_ch_q,    out_ch_d;
    logic [SW-1:0]   ptr_q,       ptr_d;

    logic            can_load_s;
    logic            rr_hit_s;
    logic [SW-1:0]   rr_idx_s;
    logic [SW:0]     rr_cand_s;
    logic            pick_hit_s;
    logic [SW-1:0]   pick_idx_s;
    logic            take_s;
    logic [SW:0]     ptr_inc_s;
    logic [N_CH-1:0] in_ready_s;

    assign can_load_s = !out_valid_q || bus.out_ready;

    // Round-robin search: walk from the farthest candidate back toward ptr so
    // the last hit recorded is the one closest to ptr.
    always_comb begin
        rr_hit_s  = 1'b0;
        rr_idx_s  = '0;
        rr_cand_s = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            rr_cand_s = {1'b0, ptr_q} + (SW+1)'(i);
            if (rr_cand_s >= N_CH_W) begin
                rr_cand_s = rr_cand_s - N_CH_W;
            end else begin
                rr_cand_s = rr_cand_s;
            end
            if (bus.in_valid[rr_cand_s[SW-1:0]]) begin
                rr_hit_s = 1'b1;
                rr_idx_s = rr_cand_s[SW-1:0];
            end else begin
                rr_hit_s = rr_hit_s;
                rr_idx_s = rr_idx_s;
            end
        end
    end

    // Pick the candidate channel for this cycle and drive the one-hot ready.
    // Fixed mode offers ready on sel whether or not that channel is valid.
    always_comb begin
        pick_hit_s = 1'b0;
        pick_idx_s = '0;
        in_ready_s = '0;
        case (bus.mode)
            1'b0: begin
                pick_hit_s = ({1'b0, bus.sel} < N_CH_W);
                pick_idx_s = bus.sel;
            end
            1'b1: begin
                pick_hit_s = rr_hit_s;
                pick_idx_s = rr_idx_s;
            end
            default: begin
                pick_hit_s = 1'b0;
                pick_idx_s = '0;
            end
        endcase
        if (pick_hit_s && can_load_s && rst_n) begin
            in_ready_s[pick_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    assign take_s    = pick_hit_s && can_load_s && bus.in_valid[pick_idx_s];
    assign ptr_inc_s = {1'b0, pick_idx_s} + {{SW{1'b0}}, 1'b1};

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (take_s) begin
            out_data_d  = bus.in_data[pick_idx_s*DW +: DW];
            out_ch_d    = pick_idx_s;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                // Wrap explicitly so non-power-of-2 N_CH returns to 0.
                if (ptr_inc_s >= N_CH_W) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_inc_s[SW-1:0];
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset empties the output stage and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed table-driven bench for stream_mux_rr with N_CH=4, DW=8, plus
// hand-written sequences for backpressure and asynchronous reset.
module tb_stream_mux_rr;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    stream_mux_rr_if #(.N_CH(4), .DW(8)) bus ();

    stream_mux_rr #(.N_CH(4), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_v;
        logic [7:0] e_d;
        logic [1:0] e_c;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, check ready combinationally, clock once, check registers.
    task automatic step(input string name, input logic mode, input logic [1:0] sel,
                        input logic [3:0] vld, input logic [31:0] data, input logic ordy,
                        input logic [3:0] e_rdy, input logic e_v,
                        input logic [7:0] e_d, input logic [1:0] e_c);
        bus.mode      = mode;
        bus.sel       = sel;
        bus.in_valid  = vld;
        bus.in_data   = data;
        bus.out_ready = ordy;
        #1;
        chk({name, ".in_ready"}, 64'(bus.in_ready), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk({name, ".out_valid"}, 64'(bus.out_valid), 64'(e_v));
        chk({name, ".out_data"}, 64'(bus.out_data), 64'(e_d));
        chk({name, ".out_ch"}, 64'(bus.out_ch), 64'(e_c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d_tbl;
        logic [31:0] d_bp;
        n_checks = 0;
        n_errors = 0;
        d_tbl = {8'h44, 8'h33, 8'h22, 8'h11};
        d_bp  = {8'hC4, 8'hC3, 8'hA5, 8'hC1};

        //         mode  sel    vld      ordy  e_rdy    e_v   e_d    e_c
        tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[10] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[11] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h44, 2'd3};
        tbl[12] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b1000, 1'b0, 8'h44, 2'd3};
        tbl[13] = '{1'b1, 2'd3, 4'b0111, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[14] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};
        tbl[15] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2};
        tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};

        // Reset state, with inputs that would otherwise be accepted.
        rst_n         = 1'b0;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = d_tbl;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.out_data", 64'(bus.out_data), 64'd0);
        chk("reset.out_ch", 64'(bus.out_ch), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), tbl[i].mode, tbl[i].sel, tbl[i].vld, d_tbl,
                 tbl[i].ordy, tbl[i].e_rdy, tbl[i].e_v, tbl[i].e_d, tbl[i].e_c);
        end

        // Backpressure while holding A5 from channel 1 (ptr is 0 here).
        step("bp_drain", 1'b1, 2'd0, 4'b0000, d_bp, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3);
        step("bp_load", 1'b1, 2'd0, 4'b0010, d_bp, 1'b0, 4'b0010, 1'b1, 8'hA5, 2'd1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("bp_hold%0d", i), 1'b1, 2'd0, 4'b1111, d_bp, 1'b0,
                 4'b0000, 1'b1, 8'hA5, 2'd1);
        end
        // ptr is 2 after the channel-1 grant: drain and reload channel 2 together.
        step("bp_release", 1'b1, 2'd0, 4'b1111, d_bp, 1'b1, 4'b0100, 1'b1, 8'hC3, 2'd2);

        // Asynchronous reset mid-cycle while out_valid is high.
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst.out_data", 64'(bus.out_data), 64'd0);
        chk("async_rst.in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 2'd0, 4'b0110, d_bp, 1'b1, 4'b0010, 1'b1, 8'hA5, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter DW, default 8: data width per channel, legal range 1..64.
REQ-003 Derived localparam SW = clog2(N_CH): channel index width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SW  channel index used in fixed mode; ignored in round-robin mode.
REQ-008 in_data  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-009 in_valid  input  N_CH  per-channel valid.
REQ-010 in_ready  output  N_CH  per-channel ready, combinational.
REQ-011 out_data  output  DW  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ch  output  SW  registered index of the channel that sourced out_data.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Output stage is a single-entry register. can_load = !out_valid | out_ready.
REQ-016 Input transfer on channel k occurs when in_valid[k] & in_ready[k]. Output transfer occurs when out_valid & out_ready.
REQ-017 At most one in_ready bit is high in any cycle. in_ready is all-zero when can_load = 0.
REQ-018 Fixed mode: in_ready[sel] = can_load and all other bits are 0. If sel >= N_CH, in_ready is all-zero.
REQ-019 Round-robin mode: grant goes to the first k with in_valid[k] = 1, searching ptr, ptr+1, ... modulo N_CH. in_ready[grant] = can_load. No valid input gives an all-zero in_ready.
REQ-020 ptr is SW bits wide. After a round-robin input transfer from channel g, ptr becomes (g+1) mod N_CH, wrapping N_CH-1 to 0 for non-power-of-2 N_CH.
REQ-021 ptr is unchanged by fixed-mode transfers and by cycles with no transfer.
REQ-022 Input transfer on k: next cycle out_data = in_data[k], out_ch = k, out_valid = 1. Latency is exactly 1 cycle.
REQ-023 Output transfer with no input transfer in the same cycle: next cycle out_valid = 0. out_data and out_ch hold their values.
REQ-024 Simultaneous output and input transfer: the register reloads with the new beat. This gives full throughput of 1 beat per cycle with no bubble.
REQ-025 Backpressure: while out_valid & !out_ready, out_data, out_ch and out_valid hold stable.
REQ-026 A mode or sel change takes effect combinationally in the same cycle. It never corrupts a beat already held in the output register.
REQ-027 No beat is dropped or duplicated. Every accepted beat appears exactly once on the output.

Reset
REQ-028 While rst_n = 0: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, and in_ready is all-zero.
REQ-029 Reset asserted mid-operation discards any held beat immediately, without waiting for a clock edge.
REQ-030 After rst_n deasserts, the first acceptance may occur on the first rising edge.

Verification (N_CH=4, DW=8)
REQ-031 Fixed mode, sel=2, in_valid=4'b1111, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'h33, out_ch=2, out_valid=1.
REQ-032 Round-robin mode, ptr=0, all valid, out_ready=1 for 5 cycles -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no gap.
REQ-033 Round-robin mode, in_valid=4'b1001, ptr=1 -> channel 3 granted, then channel 0, then channel 3; ptr after the first grant = 0.
REQ-034 Round-robin mode, out_ready=0 for 3 cycles while holding 8'hA5 -> out_data=8'hA5 stable, in_ready=0; out_ready=1 -> beat drains and the next beat loads in the same cycle.
REQ-035 Fixed mode, sel=3, in_valid=4'b0111 -> no transfer, out_valid stays 0; switch to round-robin mode -> channel 0 is accepted next edge.
REQ-036 rst_n pulled low asynchronously while out_valid=1 -> out_valid=0 before the next clock edge; after release with ptr=0, the first round-robin grant goes to the lowest valid channel.
